// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two write-back producers (ALU path A, load path M) and the shared
// register-file write port of regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          avalid;
    logic [AW-1:0] areg;
    logic [DW-1:0] adata;
    logic          aready;
    logic          mvalid;
    logic [AW-1:0] mreg;
    logic [DW-1:0] mdata;
    logic          mready;
    logic          regwrite;
    logic [AW-1:0] writereg;
    logic [DW-1:0] writedata;
    logic          idle;

    modport slave (
        input  avalid, areg, adata, mvalid, mreg, mdata,
        output aready, mready, regwrite, writereg, writedata, idle
    );

    modport master (
        output avalid, areg, adata, mvalid, mreg, mdata,
        input  aready, mready, regwrite, writereg, writedata, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing one register-file write port between ALU (A) and load (M).
// Optional macro WB_ZERO_DROP_EN: accepted writes to register 0 are discarded without a write pulse.
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_arbiter_if.slave bus
);
    typedef enum logic {SRC_A = 1'b0, SRC_M = 1'b1} src_t;

    logic          r_bufAValid;
    logic [AW-1:0] r_bufAReg;
    logic [DW-1:0] r_bufAData;
    logic          r_bufMValid;
    logic [AW-1:0] r_bufMReg;
    logic [DW-1:0] r_bufMData;
    src_t          r_last;
    src_t          r_older;
    logic          r_regwrite;
    logic [AW-1:0] r_writereg;
    logic [DW-1:0] r_writedata;

    logic w_grantA;
    logic w_grantM;
    logic w_accA;
    logic w_accM;
    logic w_loadA;
    logic w_loadM;

    // Same-register pairs follow program order; otherwise alternate away from the last winner.
    always_comb begin
        w_grantA = 1'b0;
        w_grantM = 1'b0;
        if (r_bufAValid && r_bufMValid) begin
            if (r_bufAReg == r_bufMReg) begin
                if (r_older == SRC_A) w_grantA = 1'b1;
                else                  w_grantM = 1'b1;
            end else begin
                if (r_last == SRC_M) w_grantA = 1'b1;
                else                 w_grantM = 1'b1;
            end
        end else if (r_bufAValid) begin
            w_grantA = 1'b1;
        end else if (r_bufMValid) begin
            w_grantM = 1'b1;
        end
    end

    assign bus.aready = !r_bufAValid || w_grantA;
    assign bus.mready = !r_bufMValid || w_grantM;
    assign w_accA     = bus.avalid && bus.aready;
    assign w_accM     = bus.mvalid && bus.mready;

`ifdef WB_ZERO_DROP_EN
    assign w_loadA = w_accA && (bus.areg != '0);
    assign w_loadM = w_accM && (bus.mreg != '0);
`else
    assign w_loadA = w_accA;
    assign w_loadM = w_accM;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bufAValid <= 1'b0;
            r_bufAReg   <= '0;
            r_bufAData  <= '0;
            r_bufMValid <= 1'b0;
            r_bufMReg   <= '0;
            r_bufMData  <= '0;
        end else begin
            if (w_loadA) begin
                r_bufAValid <= 1'b1;
                r_bufAReg   <= bus.areg;
                r_bufAData  <= bus.adata;
            end else if (w_grantA) begin
                r_bufAValid <= 1'b0;
            end
            if (w_loadM) begin
                r_bufMValid <= 1'b1;
                r_bufMReg   <= bus.mreg;
                r_bufMData  <= bus.mdata;
            end else if (w_grantM) begin
                r_bufMValid <= 1'b0;
            end
        end
    end

    // A freshly loaded buffer is always the younger one; a simultaneous load makes A older.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_older <= SRC_A;
        end else if (w_loadA && w_loadM) begin
            r_older <= SRC_A;
        end else if (w_loadA) begin
            r_older <= SRC_M;
        end else if (w_loadM) begin
            r_older <= SRC_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwrite  <= 1'b0;
            r_writereg  <= '0;
            r_writedata <= '0;
            r_last      <= SRC_M;
        end else if (w_grantA) begin
            r_regwrite  <= 1'b1;
            r_writereg  <= r_bufAReg;
            r_writedata <= r_bufAData;
            r_last      <= SRC_A;
        end else if (w_grantM) begin
            r_regwrite  <= 1'b1;
            r_writereg  <= r_bufMReg;
            r_writedata <= r_bufMData;
            r_last      <= SRC_M;
        end else begin
            r_regwrite  <= 1'b0;
        end
    end

    assign bus.regwrite  = r_regwrite;
    assign bus.writereg  = r_writereg;
    assign bus.writedata = r_writedata;
    assign bus.idle      = !r_bufAValid && !r_bufMValid && !r_regwrite;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued in program order and
// popped by a monitor on every regwrite pulse.
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    wr_t  expQ[$];
    wr_t  monExp;
    int   nCompared = 0;
    int   nMismatched = 0;
    int   aCnt;
    int   mCnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    regfile_wb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectWrite(input logic [AW-1:0] r, input logic [DW-1:0] d);
        expQ.push_back({r, d});
    endtask

    task automatic applyStimulus(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                                 input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        @(negedge clk);
        bus.avalid = av;
        bus.areg   = ar;
        bus.adata  = ad;
        bus.mvalid = mv;
        bus.mreg   = mr;
        bus.mdata  = md;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_regwrite"},  bus.regwrite, 0);
        checkOutput({tag, "_writereg"},  bus.writereg, 0);
        checkOutput({tag, "_writedata"}, bus.writedata, 0);
        checkOutput({tag, "_aready"},    bus.aready, 1);
        checkOutput({tag, "_mready"},    bus.mready, 1);
        checkOutput({tag, "_idle"},      bus.idle, 1);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.regwrite === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousWrite", bus.regwrite, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("writereg", bus.writereg, monExp.r);
                checkOutput("writedata", bus.writedata, monExp.d);
            end
        end
    end

    initial begin
        bus.avalid = 1'b0; bus.areg = '0; bus.adata = '0;
        bus.mvalid = 1'b0; bus.mreg = '0; bus.mdata = '0;
        #2 reset = 1'b1;
        #1 checkResetState("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] single source");
        for (int i = 0; i < 4; i++) expectWrite(AW'(3 + i), DW'(32'h10 + i));
        applyStimulus(1, 3, 32'h10, 0, 0, 0);
        checkOutput("singleReady0", bus.aready, 1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1, AW'(3 + i), DW'(32'h10 + i), 0, 0, 0);
            checkOutput("singleReady", bus.aready, 1);
            checkOutput("singleRegwrite", bus.regwrite, (i >= 2) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("singleRegwriteTail0", bus.regwrite, 1);
        @(negedge clk);
        checkOutput("singleRegwriteTail1", bus.regwrite, 1);
        @(negedge clk);
        checkOutput("singleRegwriteEnd", bus.regwrite, 0);
        checkOutput("singleIdle", bus.idle, 1);
        checkOutput("singleDrained", expQ.size(), 0);

        $display("[TB] contention");
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            expectWrite(1, DW'(32'hA0 + i));
            expectWrite(2, DW'(32'hB0 + i));
        end
        aCnt = 0;
        mCnt = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(aCnt < 3, 1, DW'(32'hA0 + aCnt), mCnt < 3, 2, DW'(32'hB0 + mCnt));
            if (c >= 1 && c <= 4) begin
                checkOutput("contAready", bus.aready, c % 2);
                checkOutput("contMready", bus.mready, 1 - (c % 2));
            end
            if (bus.avalid && bus.aready) aCnt++;
            if (bus.mvalid && bus.mready) mCnt++;
        end
        checkOutput("contAcceptA", aCnt, 3);
        checkOutput("contAcceptM", mCnt, 3);
        checkOutput("contDrained", expQ.size(), 0);

        $display("[TB] same-register order");
        expectWrite(7, 32'h7777);
        expectWrite(8, 32'hAAAA);
        expectWrite(8, 32'hBBBB);
        applyStimulus(1, 7, 32'h7777, 1, 8, 32'hAAAA);
        applyStimulus(1, 8, 32'hBBBB, 0, 0, 0);
        checkOutput("orderAready", bus.aready, 1);
        checkOutput("orderMready", bus.mready, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("orderMreadyHeld", bus.mready, 1);
        checkOutput("orderAreadyHeld", bus.aready, 0);
        repeat (4) @(negedge clk);
        checkOutput("orderDrained", expQ.size(), 0);

        $display("[TB] same-edge same-register");
        expectWrite(9, 32'h9A);
        expectWrite(9, 32'h9B);
        applyStimulus(1, 9, 32'h9A, 1, 9, 32'h9B);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("sameEdgeAready", bus.aready, 1);
        checkOutput("sameEdgeMready", bus.mready, 0);
        repeat (4) @(negedge clk);
        checkOutput("sameEdgeDrained", expQ.size(), 0);

        $display("[TB] zero register");
`ifndef WB_ZERO_DROP_EN
        expectWrite(0, 32'hFFFF);
`endif
        applyStimulus(1, 0, 32'hFFFF, 0, 0, 0);
        checkOutput("zeroAready", bus.aready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("zeroRegwrite0", bus.regwrite, 0);
`ifdef WB_ZERO_DROP_EN
        checkOutput("zeroIdle0", bus.idle, 1);
        @(negedge clk);
        checkOutput("zeroRegwrite1", bus.regwrite, 0);
        checkOutput("zeroIdle1", bus.idle, 1);
`else
        checkOutput("zeroIdle0", bus.idle, 0);
        @(negedge clk);
        checkOutput("zeroRegwrite1", bus.regwrite, 1);
        checkOutput("zeroWritereg", bus.writereg, 0);
`endif
        @(negedge clk);
        checkOutput("zeroIdleEnd", bus.idle, 1);
        checkOutput("zeroDrained", expQ.size(), 0);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 10, 32'h1010, 1, 11, 32'h1111);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midBusy", bus.idle, 0);
        #2 reset = 1'b1;
        #1 checkResetState("midReset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("postResetRegwrite", bus.regwrite, 0);
        end
        checkOutput("postResetIdle", bus.idle, 1);
        checkOutput("finalDrained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
